// File: rtl/display_7seg_scan_controller.sv
// rtl/display_7seg_scan_controller.sv - time-multiplexed 7-segment scan controller
//
// Purpose:
//   Scans NUM_DIGITS common-anode 7-segment digits, one slot of REFRESH_DIV
//   clocks per digit.  The first BLANK_CYCLES clocks of each slot keep every
//   anode off to suppress ghosting.  Value writes arrive over a valid/ready
//   handshake, are parked in a one-deep pending register and are committed to
//   the displayed value only when the scan wraps back to digit 0.  As a result,
//   a frame never shows a mix of old and new digits.
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When defined, digits above the most significant nonzero nibble of the
//   displayed value are dark.  Digit 0 is always eligible to light.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   synchronous reset, active-low
//   wr_valid    in   value write request
//   wr_data     in   new value, nibble k drives digit k (digit 0 rightmost)
//   wr_ready    out  write can be accepted (no value pending)
//   mask_we     in   load mask_data into the digit-enable mask next edge
//   mask_data   in   per-digit enable, 1 = digit may light
//   rd_value    out  currently displayed (committed) value
//   seg_out     out  segments {g,f,e,d,c,b,a}, active-low, registered
//   digit_an    out  anode selects, active-low, registered
//   frame_tick  out  1-cycle pulse after the scan wraps to digit 0
module display_7seg_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    mask_we,
  input  logic [NUM_DIGITS-1:0]   mask_data,
  output logic [4*NUM_DIGITS-1:0] rd_value,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_tick
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  logic [DIV_W-1:0]        div_cnt_q,   div_cnt_d;
  logic [IDX_W-1:0]        scan_idx_q,  scan_idx_d;
  logic [4*NUM_DIGITS-1:0] shown_q,     shown_d;
  logic [4*NUM_DIGITS-1:0] pending_q,   pending_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0]   mask_q,      mask_d;
  logic [6:0]              seg_q,       seg_d;
  logic [NUM_DIGITS-1:0]   an_q,        an_d;
  logic                    tick_q,      tick_d;

  logic             slot_wrap;
  logic             frame_wrap;
  logic             commit;
  logic [3:0]       nibble;
  logic             digit_lit;

  // Active-low segment patterns for hex digits 0..F.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msnz_q, msnz_d;

  // Index of the highest nonzero nibble; 0 when the value is all zeros.
  function automatic logic [IDX_W-1:0] find_msnz(input logic [4*NUM_DIGITS-1:0] v);
    find_msnz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] != 4'h0) find_msnz = IDX_W'(k);
    end
  endfunction
`endif

  always_comb begin
    slot_wrap  = (div_cnt_q == DIV_LAST);
    frame_wrap = slot_wrap && (scan_idx_q == IDX_LAST);
    div_cnt_d  = slot_wrap ? '0 : div_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (slot_wrap) scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    tick_d = frame_wrap;
  end

  // Commit and accept are mutually exclusive: accepting needs pend_flag=0,
  // committing needs pend_flag=1.  A write landing in the wrap cycle
  // therefore waits for the following frame.
  always_comb begin
    commit      = frame_wrap && pend_flag_q;
    shown_d     = shown_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    if (commit) begin
      shown_d     = pending_q;
      pend_flag_d = 1'b0;
    end else if (wr_valid && !pend_flag_q) begin
      pending_d   = wr_data;
      pend_flag_d = 1'b1;
    end
    mask_d = mask_we ? mask_data : mask_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    msnz_d = msnz_q;
    if (commit) msnz_d = find_msnz(pending_q);
  end
`endif

  // Output stage: one-cycle latency from div_cnt/scan_idx.  Only one
  // one-hot anode is ever produced, so at most one digit is driven.
  always_comb begin
    nibble    = shown_q[{scan_idx_q, 2'b00} +: 4];
    digit_lit = mask_q[scan_idx_q] && (div_cnt_q >= BLANK_END);
`ifdef LEADING_ZERO_BLANK_EN
    digit_lit = digit_lit && (scan_idx_q <= msnz_q);
`endif
    an_d  = digit_lit ? ~(ONE_HOT0 << scan_idx_q) : '1;
    seg_d = digit_lit ? hex7(nibble) : 7'h7F;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      scan_idx_q  <= '0;
      shown_q     <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      mask_q      <= '1;
      seg_q       <= 7'h7F;
      an_q        <= '1;
      tick_q      <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      scan_idx_q  <= scan_idx_d;
      shown_q     <= shown_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      mask_q      <= mask_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      tick_q      <= tick_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_ff @(posedge clock) begin
    if (!reset_n) msnz_q <= '0;
    else          msnz_q <= msnz_d;
  end
`endif

  assign wr_ready   = ~pend_flag_q;
  assign rd_value   = shown_q;
  assign seg_out    = seg_q;
  assign digit_an   = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_7seg_scan_controller.sv
// tb/tb_display_7seg_scan_controller.sv - directed bench for the 7-segment scan controller
module tb_display_7seg_scan_controller;

  localparam int ND = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic          mask_we;
  logic [3:0]    mask_data;
  logic [15:0]   rd_value;
  logic [6:0]    seg_out;
  logic [3:0]    digit_an;
  logic          frame_tick;

  int total = 0;
  int bad   = 0;
  int multi_low = 0;

  display_7seg_scan_controller #(
    .NUM_DIGITS(ND), .REFRESH_DIV(8), .BLANK_CYCLES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .mask_we(mask_we), .mask_data(mask_data),
    .rd_value(rd_value), .seg_out(seg_out), .digit_an(digit_an),
    .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n === 1'b1 && $countones(~digit_an) > 1) multi_low++;
  end

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] value;
    logic [15:0] an_all;   // slot k anode pattern in [4k+:4]
    logic [27:0] seg_all;  // slot k segment pattern in [7k+:7]
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Ticks at least once, then stops at the first negedge showing frame_tick.
  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    if (frame_tick !== 1'b1) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_value(input logic [15:0] v);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = v;
    while (wr_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (wr_ready !== 1'b1) check("write_timeout", 32'd0, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we   = 1'b1;
    mask_data = m;
    tick();
    mask_we   = 1'b0;
  endtask

  initial begin
    int n;
    logic early;

    vecs[0] = '{4'hF, 16'h1234, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{4'hF, 16'hBEEF, 16'h7BDE, {7'h03, 7'h06, 7'h06, 7'h0E}};
    vecs[2] = '{4'h5, 16'h89AC, 16'hFBFE, {7'h7F, 7'h10, 7'h7F, 7'h46}};
    vecs[3] = '{4'hA, 16'h5678, 16'h7FDF, {7'h12, 7'h7F, 7'h78, 7'h7F}};
    vecs[4] = '{4'h3, 16'hF00D, 16'hFFDE, {7'h7F, 7'h7F, 7'h40, 7'h21}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[5] = '{4'hF, 16'h0070, 16'hFFDE, {7'h7F, 7'h7F, 7'h78, 7'h40}};
    vecs[6] = '{4'hF, 16'h0000, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
`else
    vecs[5] = '{4'hF, 16'h0070, 16'h7BDE, {7'h40, 7'h40, 7'h78, 7'h40}};
    vecs[6] = '{4'hF, 16'h0000, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}};
`endif

    reset_n   = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = 16'h0;
    mask_we   = 1'b0;
    mask_data = 4'h0;

    // Reset state
    repeat (3) tick();
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_an", 32'(digit_an), 32'hF);
    check("rst_ready", 32'(wr_ready), 32'h1);
    check("rst_value", 32'(rd_value), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("first_blank_an", 32'(digit_an), 32'hF);
    tick();
    check("first_lit_an", 32'(digit_an), 32'hE);
    check("first_lit_seg", 32'(seg_out), 32'h40);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      set_mask(vecs[i].mask);
      write_value(vecs[i].value);
      wait_frame();
      check($sformatf("v%0d_value", i), 32'(rd_value), 32'(vecs[i].value));
      for (int k = 0; k < ND; k++) begin
        repeat (2) tick();
        check($sformatf("v%0d_s%0d_blank", i, k), 32'(digit_an), 32'hF);
        repeat (2) tick();
        check($sformatf("v%0d_s%0d_an", i, k), 32'(digit_an), 32'(vecs[i].an_all[4*k +: 4]));
        check($sformatf("v%0d_s%0d_seg", i, k), 32'(seg_out), 32'(vecs[i].seg_all[7*k +: 7]));
        repeat (4) tick();
      end
    end
    set_mask(4'hF);

    // Handshake: second write held off until the first commits
    wait_frame();
    check("hs_ready0", 32'(wr_ready), 32'h1);
    wr_valid = 1'b1;
    wr_data  = 16'h1357;
    tick();
    check("hs_busy", 32'(wr_ready), 32'h0);
    wr_data = 16'hBEEF;
    early = 1'b0;
    n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      if (wr_ready === 1'b1) early = 1'b1;
      tick();
      n++;
    end
    check("hs_no_early_ready", 32'(early), 32'h0);
    check("hs_commit_a", 32'(rd_value), 32'h1357);
    check("hs_ready_back", 32'(wr_ready), 32'h1);
    tick();
    wr_valid = 1'b0;
    check("hs_second_taken", 32'(wr_ready), 32'h0);
    check("hs_a_held", 32'(rd_value), 32'h1357);
    wait_frame();
    check("hs_commit_b", 32'(rd_value), 32'hBEEF);

    // Write in the exact wrap cycle commits one frame later
    repeat (31) tick();
    check("bd_ready", 32'(wr_ready), 32'h1);
    wr_valid = 1'b1;
    wr_data  = 16'h2468;
    tick();
    wr_valid = 1'b0;
    check("bd_tick", 32'(frame_tick), 32'h1);
    check("bd_not_yet", 32'(rd_value), 32'hBEEF);
    check("bd_accepted", 32'(wr_ready), 32'h0);
    wait_frame();
    check("bd_commit", 32'(rd_value), 32'h2468);

    // Frame period
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    check("frame_period", 32'(n), 32'd32);

    // Reset while a value is pending
    set_mask(4'h5);
    wr_valid = 1'b1;
    wr_data  = 16'h1111;
    tick();
    wr_valid = 1'b0;
    check("rp_pending", 32'(wr_ready), 32'h0);
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    check("rp_value", 32'(rd_value), 32'h0);
    check("rp_ready", 32'(wr_ready), 32'h1);
    check("rp_an", 32'(digit_an), 32'hF);
    wait_frame();
    wait_frame();
    check("rp_discarded", 32'(rd_value), 32'h0);
    repeat (12) tick();
`ifdef LEADING_ZERO_BLANK_EN
    check("rp_mask_an", 32'(digit_an), 32'hF);
`else
    check("rp_mask_an", 32'(digit_an), 32'hD);
    check("rp_mask_seg", 32'(seg_out), 32'h40);
`endif

    check("one_anode_max", 32'(multi_low), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
